// File: rtl/ped_xing_pkg.sv
// Shared types and display codes for the pedestrian-crossing controller.
// The NIGHT state exists only when NIGHT_MODE_EN is defined.
package ped_xing_pkg;

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED1   = 3'd2,
    PED_WALK   = 3'd3,
    PED_FLASH  = 3'd4,
    ALL_RED2   = 3'd5
`ifdef NIGHT_MODE_EN
    , NIGHT    = 3'd6
`endif
  } state_e;

  // ped_state codes, one-hot {walk, flashing_dont_walk, dont_walk}
  localparam logic [2:0] OFF              = 3'b000;
  localparam logic [2:0] DONTWALK         = 3'b001;
  localparam logic [2:0] FLASHINGDONTWALK = 3'b010;
  localparam logic [2:0] WALK             = 3'b100;

  // car_lights codes, {red, yellow, green}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  function automatic int max_dur(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic logic [2:0] ped_of(input state_e s);
    case (s)
      PED_WALK:  return WALK;
      PED_FLASH: return FLASHINGDONTWALK;
`ifdef NIGHT_MODE_EN
      NIGHT:     return OFF;
`endif
      default:   return DONTWALK;
    endcase
  endfunction

  function automatic logic [2:0] car_of(input state_e s);
    case (s)
      CAR_GREEN:  return GREEN;
      CAR_YELLOW: return YELLOW;
      default:    return RED;
    endcase
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_tick_gen.sv
// Timing prescaler: one-clk tick strobe every TICK_DIV clk cycles.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(TICK_DIV - 1));
  assign tick   = w_last;

  // NOTE: state is updated with non-blocking assignments only; the reset is
  // synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n)    r_count <= '0;
    else if (w_last) r_count <= '0;
    else             r_count <= r_count + 1'b1;
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Timed pedestrian-crossing controller: vehicle light sequence plus walk phase.
// Define NIGHT_MODE_EN to add the night_mode input and the flashing-yellow NIGHT state.
module ped_crossing_ctrl
  import ped_xing_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GREEN_MIN = 10,
  parameter int YELLOW_T  = 3,
  parameter int CLEAR_T   = 2,
  parameter int WALK_T    = 7,
  parameter int FLASH_T   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       walk_request,
`ifdef NIGHT_MODE_EN
  input  logic       night_mode,
`endif
  output logic [2:0] ped_state,
  output logic [2:0] car_lights,
  output logic       request_pending,
  output logic       tick
);

  localparam int MAX_T = max_dur(GREEN_MIN, YELLOW_T, CLEAR_T, WALK_T, FLASH_T);
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic          r_req;
  logic [2:0]    r_ped;
  logic [2:0]    r_car;

  state_e        w_next;
  int            w_dur;
  logic          w_expired;
  logic          w_clear_req;
  logic [2:0]    w_car_next;
  logic          w_tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  always_comb begin
    w_dur = 1;
    case (r_state)
      CAR_GREEN:  w_dur = GREEN_MIN;
      CAR_YELLOW: w_dur = YELLOW_T;
      ALL_RED1:   w_dur = CLEAR_T;
      PED_WALK:   w_dur = WALK_T;
      PED_FLASH:  w_dur = FLASH_T;
      ALL_RED2:   w_dur = CLEAR_T;
      default:    w_dur = 1;
    endcase
  end

  // Timer never counts past duration-1; in green this is the saturation point.
  assign w_expired = (r_timer == TW'(w_dur - 1));

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      CAR_GREEN: begin
`ifdef NIGHT_MODE_EN
        if (night_mode) w_next = NIGHT;
        else
`endif
        if (w_tick && r_req && w_expired) w_next = CAR_YELLOW;
      end
      CAR_YELLOW: if (w_tick && w_expired) w_next = ALL_RED1;
      ALL_RED1:   if (w_tick && w_expired) w_next = PED_WALK;
      PED_WALK:   if (w_tick && w_expired) w_next = PED_FLASH;
      PED_FLASH:  if (w_tick && w_expired) w_next = ALL_RED2;
      ALL_RED2:   if (w_tick && w_expired) w_next = CAR_GREEN;
`ifdef NIGHT_MODE_EN
      NIGHT:      if (!night_mode) w_next = CAR_GREEN;
`endif
      default:    w_next = ALL_RED2;
    endcase
  end

  always_comb begin
    w_car_next  = car_of(w_next);
    w_clear_req = (w_next == PED_WALK) && (r_state != PED_WALK);
`ifdef NIGHT_MODE_EN
    if (w_next == NIGHT) begin
      w_clear_req = 1'b1;
      if (r_state != NIGHT) w_car_next = YELLOW;
      else if (w_tick)      w_car_next = r_car ^ YELLOW;
      else                  w_car_next = r_car;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= CAR_GREEN;
      r_timer <= '0;
      r_req   <= 1'b0;
      r_ped   <= DONTWALK;
      r_car   <= GREEN;
    end else begin
      r_state <= w_next;
      r_ped   <= ped_of(w_next);
      r_car   <= w_car_next;
      if (w_next != r_state)         r_timer <= '0;
      else if (w_tick && !w_expired) r_timer <= r_timer + 1'b1;
      if (w_clear_req)                                r_req <= 1'b0;
      else if (walk_request && r_state != PED_WALK)   r_req <= 1'b1;
    end
  end

  assign ped_state       = r_ped;
  assign car_lights      = r_car;
  assign request_pending = r_req;
  assign tick            = w_tick;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench: a phase-table reference model queues the expected outputs
// for every cycle; an independent monitor compares them on the falling edge.
module tb_ped_crossing_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int GREEN_MIN = 3;
  localparam int YELLOW_T  = 2;
  localparam int CLEAR_T   = 1;
  localparam int WALK_T    = 3;
  localparam int FLASH_T   = 2;

  typedef struct packed {
    logic [2:0] ped;
    logic [2:0] car;
    logic       req;
    logic       tk;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       walk_request = 1'b0;
  logic [2:0] ped_state;
  logic [2:0] car_lights;
  logic       request_pending;
  logic       tick;
`ifdef NIGHT_MODE_EN
  logic       night_mode = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  // Phase table: green, yellow, all-red, walk, flash, all-red.
  int         ph_dur[6] = '{0, YELLOW_T, CLEAR_T, WALK_T, FLASH_T, CLEAR_T};
  logic [2:0] ph_ped[6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
  logic [2:0] ph_car[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};

  int m_phase, m_left, m_green_ticks, m_cyc;
  bit m_req;
  bit armed = 0;

  ped_crossing_ctrl #(
    .TICK_DIV (TICK_DIV),
    .GREEN_MIN(GREEN_MIN),
    .YELLOW_T (YELLOW_T),
    .CLEAR_T  (CLEAR_T),
    .WALK_T   (WALK_T),
    .FLASH_T  (FLASH_T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .walk_request   (walk_request),
`ifdef NIGHT_MODE_EN
    .night_mode     (night_mode),
`endif
    .ped_state      (ped_state),
    .car_lights     (car_lights),
    .request_pending(request_pending),
    .tick           (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got ped=%b car=%b req=%b tick=%b, want ped=%b car=%b req=%b tick=%b",
               name, $time, act.ped, act.car, act.req, act.tk,
               exp.ped, exp.car, exp.req, exp.tk);
    end
  endtask

  // Advance the model across one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit tk;
    int old_phase;
    bit entered_walk;
    if (!reset_n) begin
      m_phase = 0; m_left = 0; m_green_ticks = 0; m_req = 0; m_cyc = 0;
      armed = 1;
      return;
    end
    tk = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    old_phase = m_phase;
    entered_walk = 0;
    if (tk) begin
      if (m_phase == 0) begin
        if (m_req && m_green_ticks >= GREEN_MIN - 1) begin
          m_phase = 1;
          m_left  = ph_dur[1];
        end else begin
          m_green_ticks++;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_phase = (m_phase + 1) % 6;
          entered_walk = (m_phase == 3);
          if (m_phase == 0) m_green_ticks = 0;
          else              m_left = ph_dur[m_phase];
        end
      end
    end
    if (entered_walk)                        m_req = 0;
    else if (walk_request && old_phase != 3) m_req = 1;
    m_cyc++;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.ped = ph_ped[m_phase];
    o.car = ph_car[m_phase];
    o.req = m_req;
    o.tk  = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    return o;
  endfunction

  task automatic step(input logic walk, input logic rst);
    @(posedge clk);
    model_edge();
    #1;
    walk_request = walk;
    reset_n      = rst;
    if (armed) exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue head.
  initial begin
    obs_t act, exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = '{ped: ped_state, car: car_lights, req: request_pending, tk: tick};
        check("cycle", act, exp);
      end
    end
  end

  initial begin
    // Idle after reset: green, don't-walk, periodic tick.
    do_reset();
    idle(100);

    // Early request: full pedestrian cycle once green minimum elapses.
    do_reset();
    idle(1); step(1'b1, 1'b1); idle(60);

    // Late request after green minimum: yellow follows the next tick.
    do_reset();
    idle(39); step(1'b1, 1'b1); idle(50);

    // Requests during walk (ignored) and flash (kept for a second cycle).
    do_reset();
    idle(1); step(1'b1, 1'b1); idle(26);
    step(1'b1, 1'b1); idle(9);
    step(1'b1, 1'b1); idle(90);

    // Reset pulse while walking.
    do_reset();
    idle(1); step(1'b1, 1'b1); idle(26);
    step(1'b0, 1'b0); idle(40);

    // Randomized requests with rare resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 14) == 0), ($urandom_range(0, 399) != 0));

    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Timed pedestrian-crossing controller.
- Sequences the vehicle lights and produces the one-hot pedestrian state {walk, flashing_dont_walk, dont_walk} consumed by the pedestrian hex-display decoder.
- Registers a push-button request and runs the walk phase once the minimum vehicle green has elapsed.
- Sits between the board button/clock and the display and LED drivers.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per timing tick (1 s at 50 MHz).
- GREEN_MIN, 10: minimum ticks of vehicle green before walk is granted.
- YELLOW_T, 3: ticks of vehicle yellow.
- CLEAR_T, 2: ticks of all-red before and after the pedestrian phase.
- WALK_T, 7: ticks of WALK.
- FLASH_T, 5: ticks of flashing don't-walk.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous, active-low reset.
- walk_request, input, 1: pedestrian button, level, already synchronized.
- ped_state, output, 3: one-hot {walk, flashing_dont_walk, dont_walk}; 3'b000 means off.
- car_lights, output, 3: {red, yellow, green}.
- request_pending, output, 1: the request latch.
- tick, output, 1: one-clk timing strobe, for debug and verification.

Behaviour:
- Single clock domain clk. Reset is synchronous, active-low, on reset_n, sampled on posedge clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the one cycle where the count equals TICK_DIV-1.
  - Reset sets the count to 0.
- Timer:
  - Counts ticks within the current state; width is clog2 of the largest duration.
  - Cleared on every state change.
  - Increments on tick.
  - In CAR_GREEN it saturates at GREEN_MIN-1.
- States and registered outputs (ped_state / car_lights):
  - CAR_GREEN: 001 / 001.
  - CAR_YELLOW: 001 / 010.
  - ALL_RED1: 001 / 100.
  - PED_WALK: 100 / 100.
  - PED_FLASH: 010 / 100.
  - ALL_RED2: 001 / 100.
- Transitions are evaluated only on a tick cycle:
  - CAR_GREEN -> CAR_YELLOW when request_pending = 1 and timer = GREEN_MIN-1.
  - Each other state advances when timer = duration-1, in the order CAR_YELLOW, ALL_RED1, PED_WALK, PED_FLASH, ALL_RED2, CAR_GREEN.
  - The next state appears on the outputs the cycle after the tick.
- Request latch:
  - Sets on any cycle where walk_request = 1 and the state is not PED_WALK.
  - Clears on the cycle the state enters PED_WALK; clear wins over a simultaneous set.
  - A request during PED_FLASH or ALL_RED2 is kept and serves the next cycle.
  - A request arriving after GREEN_MIN has elapsed takes effect at the next tick.
- Reset values: state CAR_GREEN, timer 0, prescaler 0, latch 0, ped_state 3'b001, car_lights 3'b001, tick 0.
- Reset mid-sequence (e.g. in PED_WALK) returns to CAR_GREEN the next cycle with no intermediate states.
- Output invariants: never green with ped_state != 001; never two car_lights bits set together.
- Illegal state encoding recovers to ALL_RED2 with ped_state 001 and car_lights 100.

Optional Feature:
- NIGHT_MODE_EN defined:
  - Adds input night_mode (1 bit).
  - While night_mode = 1 and the state is CAR_GREEN, the block enters NIGHT: ped_state 3'b000, car_lights toggles between 010 and 000 on every tick, and the request latch is held clear.
  - When night_mode drops, it returns to CAR_GREEN with the timer cleared.
  - night_mode asserted in any other state takes effect only on the next return to CAR_GREEN.
- NIGHT_MODE_EN undefined: no port, no NIGHT state, behaviour as above.

Decomposition:
- Package ped_xing_pkg:
  - State enum typedef.
  - localparams for the ped_state codes: OFF 3'b000, DONTWALK 3'b001, FLASHINGDONTWALK 3'b010, WALK 3'b100.
  - localparams for the car_lights codes: RED, YELLOW, GREEN.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset_n, tick), one instance.

Test Plan:
All scenarios use TICK_DIV=4, GREEN_MIN=3, YELLOW_T=2, CLEAR_T=1, WALK_T=3, FLASH_T=2.
1. Reset, no request for 100 clks -> ped_state=001 and car_lights=001 throughout; tick pulses every 4 clks.
2. One-clk walk_request at clk 2 -> request_pending=1 from clk 3. Sequence: CAR_YELLOW 8 clks, ALL_RED1 4, PED_WALK 12 (ped 100), PED_FLASH 8 (ped 010), ALL_RED2 4, then green. The latch clears on entry to WALK.
3. Request pulse at clk 40, after GREEN_MIN has elapsed -> yellow begins on the cycle after the next tick.
4. Request during PED_WALK -> ignored and the block returns to green. Request during PED_FLASH -> a second pedestrian cycle follows after 3 ticks of green.
5. reset_n=0 for 1 clk while in PED_WALK -> the next cycle shows ped 001 / car 001, the latch is 0, and the full GREEN_MIN is needed again.
6. (NIGHT_MODE_EN) night_mode=1 in green -> ped 000, car_lights alternates 010/000 per tick, and requests are not latched. Drop night_mode -> car 001 and ped 001.
